// File: rtl/ifft_pkg.sv
// Shared types, codes and helpers for the in-place radix-2 IFFT memory controller.
package ifft_pkg;

   localparam int unsigned AwDefault = 5;
   localparam int unsigned BitrevMax = 16;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StRdA,
      StRdB,
      StBfWait,
      StWrA,
      StWrB,
      StUnload
   } state_e;

   localparam logic [1:0] WselIn  = 2'b00;
   localparam logic [1:0] WselTop = 2'b01;
   localparam logic [1:0] WselBot = 2'b10;

   // Reverses the low w bits of v; bits at and above w come back as zero.
   function automatic logic [BitrevMax-1:0] bitrev(input logic [BitrevMax-1:0] v,
                                                    input int unsigned w);
      logic [BitrevMax-1:0] r;
      logic [3:0]           idx;
      r = '0;
      for (int unsigned i = 0; i < BitrevMax; i++) begin
         idx = 4'(w - 1 - i);
         if (i < w) r[i] = v[idx];
      end
      return r;
   endfunction

endpackage

// File: rtl/ifft_mem_ctrl_if.sv
// Handshake, working-memory and butterfly-unit signals of the IFFT memory controller.
interface ifft_mem_ctrl_if
   import ifft_pkg::*;
#(
   parameter int unsigned AW = AwDefault
);
   logic          in_valid;
   logic          in_ready;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] mem_waddr;
   logic          mem_write;
   logic [1:0]    mem_wsel;
   logic [AW-1:0] mem_raddr;
   logic          bf_lat_a;
   logic          bf_lat_b;
   logic          bf_start;
   logic [AW-2:0] tw_idx;
   logic          bf_done;

   modport master (
      input  in_valid, out_ready, bf_done,
      output in_ready, out_valid, mem_waddr, mem_write, mem_wsel, mem_raddr,
             bf_lat_a, bf_lat_b, bf_start, tw_idx
   );

   modport slave (
      output in_valid, out_ready, bf_done,
      input  in_ready, out_valid, mem_waddr, mem_write, mem_wsel, mem_raddr,
             bf_lat_a, bf_lat_b, bf_start, tw_idx
   );

endinterface

// File: rtl/ifft_addr_gen.sv
// Butterfly operand addresses and twiddle index for stage s, butterfly k (combinational).
module ifft_addr_gen
   import ifft_pkg::*;
#(
   parameter int unsigned AW = AwDefault,
   parameter int unsigned SW = $clog2(AW + 1)
) (
   input  logic [SW-1:0] s_i,
   input  logic [AW-2:0] k_i,
   output logic [AW-1:0] a_o,
   output logic [AW-1:0] b_o,
   output logic [AW-2:0] tw_o
);

   logic [AW-1:0] k_ext;
   logic [AW-1:0] span;
   logic [AW-1:0] pos;
   logic [AW-1:0] a;
   logic [SW-1:0] s_up;
   logic [SW-1:0] tw_sh;

   always_comb begin
      k_ext = {1'b0, k_i};
      span  = AW'(1) << s_i;
      pos   = k_ext & (span - AW'(1));
      s_up  = s_i + SW'(1);
      tw_sh = SW'(AW - 1) - s_i;
      // Group index k>>s spreads to a 2*span stride; bit s of a is always clear.
      a     = ((k_ext >> s_i) << s_up) | pos;
      a_o   = a;
      b_o   = a | span;
      tw_o  = (AW-1)'(pos << tw_sh);
   end

endmodule

// File: rtl/ifft_mem_ctrl.sv
// In-place IFFT memory sequencer: load, radix-2 butterfly passes, unload.
// Define IFFT_MEM_CTRL_BITREV_LOAD_EN to bit-reverse on load instead of on unload.
module ifft_mem_ctrl
   import ifft_pkg::*;
#(
   parameter int unsigned AW = AwDefault
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic            busy,
   output logic            frame_done,
   ifft_mem_ctrl_if.master bus
);

   localparam int unsigned   SW       = $clog2(AW + 1);
   localparam logic [AW-1:0] CntLast  = {AW{1'b1}};
   localparam logic [AW-2:0] KLast    = {(AW-1){1'b1}};
   localparam logic [SW-1:0] SLast    = SW'(AW - 1);

   state_e        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic [SW-1:0] s_q, s_d;
   logic [AW-2:0] k_q, k_d;

   logic [AW-1:0] addr_a, addr_b;
   logic [AW-2:0] tw;
   logic [AW-1:0] ld_addr, ul_addr;

   ifft_addr_gen #(
      .AW (AW),
      .SW (SW)
   ) u_addr_gen (
      .s_i  (s_q),
      .k_i  (k_q),
      .a_o  (addr_a),
      .b_o  (addr_b),
      .tw_o (tw)
   );

`ifdef IFFT_MEM_CTRL_BITREV_LOAD_EN
   assign ld_addr = AW'(bitrev(BitrevMax'(cnt_q), AW));
   assign ul_addr = cnt_q;
`else
   assign ld_addr = cnt_q;
   assign ul_addr = AW'(bitrev(BitrevMax'(cnt_q), AW));
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         s_q     <= '0;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         s_q     <= s_d;
         k_q     <= k_d;
      end
   end

   assign busy = (state_q != StIdle);

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      s_d           = s_q;
      k_d           = k_q;
      frame_done    = 1'b0;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.mem_waddr = '0;
      bus.mem_write = 1'b0;
      bus.mem_wsel  = WselIn;
      bus.mem_raddr = '0;
      bus.bf_lat_a  = 1'b0;
      bus.bf_lat_b  = 1'b0;
      bus.bf_start  = 1'b0;
      bus.tw_idx    = '0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StLoad;
               cnt_d   = '0;
            end
         end
         StLoad: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               bus.mem_write = 1'b1;
               bus.mem_wsel  = WselIn;
               bus.mem_waddr = ld_addr;
               cnt_d         = cnt_q + 1'b1;
               if (cnt_q == CntLast) begin
                  state_d = StRdA;
                  s_d     = '0;
                  k_d     = '0;
               end
            end
         end
         StRdA: begin
            bus.mem_raddr = addr_a;
            bus.bf_lat_a  = 1'b1;
            bus.tw_idx    = tw;
            state_d       = StRdB;
         end
         StRdB: begin
            bus.mem_raddr = addr_b;
            bus.bf_lat_b  = 1'b1;
            bus.bf_start  = 1'b1;
            bus.tw_idx    = tw;
            state_d       = StBfWait;
         end
         StBfWait: begin
            bus.tw_idx = tw;
            if (bus.bf_done) state_d = StWrA;
         end
         StWrA: begin
            bus.mem_waddr = addr_a;
            bus.mem_wsel  = WselTop;
            bus.mem_write = 1'b1;
            bus.tw_idx    = tw;
            state_d       = StWrB;
         end
         StWrB: begin
            bus.mem_waddr = addr_b;
            bus.mem_wsel  = WselBot;
            bus.mem_write = 1'b1;
            bus.tw_idx    = tw;
            if (k_q != KLast) begin
               k_d     = k_q + 1'b1;
               state_d = StRdA;
            end else if (s_q != SLast) begin
               s_d     = s_q + 1'b1;
               k_d     = '0;
               state_d = StRdA;
            end else begin
               cnt_d   = '0;
               state_d = StUnload;
            end
         end
         StUnload: begin
            bus.out_valid = 1'b1;
            bus.mem_raddr = ul_addr;
            if (bus.out_ready) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CntLast) begin
                  state_d    = StIdle;
                  frame_done = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

endmodule

// File: tb/tb_ifft_mem_ctrl.sv
// Scoreboard bench for ifft_mem_ctrl: randomized handshakes and butterfly latency.
module tb_ifft_mem_ctrl;

   localparam int unsigned AW = 5;
   localparam int          N  = 1 << AW;

   typedef struct {
      int kind;  // 1 load wr, 2 top wr, 3 bottom wr, 4 read A, 5 read B, 6 unload
      int addr;
      int tw;
      int last;
   } ev_t;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic busy;
   logic frame_done;

   ifft_mem_ctrl_if #(.AW(AW)) bus ();

   ifft_mem_ctrl #(.AW(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .busy       (busy),
      .frame_done (frame_done),
      .bus        (bus.master)
   );

   always #5 clk = ~clk;

   ev_t exp_q[$];
   int  lat_q[$];
   int  n_cmp = 0;
   int  n_err = 0;
   int  cyc = 0;
   int  done_cnt = 0;
   int  rdb_cnt = 0;
   int  comp_len = 0;
   int  first_rda = 0;
   int  last_wrb = 0;
   int  rdb_cyc = 0;
   int  last_kind = 0;
   int  cd = 0;
   bit  rnd_in = 0, rnd_out = 0, chaos = 0, stray_en = 0;
   int  lat_min = 1, lat_max = 1;

   function automatic void check(string name, int act, int req);
      n_cmp++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endfunction

   function automatic int brev(int v);
      int r = 0;
      for (int i = 0; i < int'(AW); i++) r = (r << 1) | ((v >> i) & 1);
      return r;
   endfunction

   function automatic int ld_addr(int i);
`ifdef IFFT_MEM_CTRL_BITREV_LOAD_EN
      return brev(i);
`else
      return i;
`endif
   endfunction

   function automatic int ul_addr(int i);
`ifdef IFFT_MEM_CTRL_BITREV_LOAD_EN
      return i;
`else
      return brev(i);
`endif
   endfunction

   // Reference sequence of memory/butterfly events for one whole frame.
   task automatic build_frame();
      for (int i = 0; i < N; i++) exp_q.push_back('{1, ld_addr(i), 0, 0});
      for (int s = 0; s < int'(AW); s++) begin
         for (int k = 0; k < N / 2; k++) begin
            int span = 1 << s;
            int pos  = k % span;
            int a    = (k / span) * 2 * span + pos;
            int b    = a + span;
            int tw   = pos * (1 << (int'(AW) - 1 - s));
            exp_q.push_back('{4, a, tw, 0});
            exp_q.push_back('{5, b, tw, 0});
            exp_q.push_back('{2, a, 0, 0});
            exp_q.push_back('{3, b, 0, 0});
         end
      end
      for (int i = 0; i < N; i++) exp_q.push_back('{6, ul_addr(i), 0, int'(i == N - 1)});
   endtask

   // Butterfly unit model: bf_done high in the L-th cycle after bf_start.
   always @(negedge clk) begin
      if (rst) begin
         cd = 0;
         bus.bf_done = 1'b0;
      end else begin
         if (cd > 0) begin
            cd--;
            bus.bf_done = (cd == 0);
         end else begin
            bus.bf_done = stray_en && ($urandom_range(0, 3) == 0);
         end
         if (bus.bf_start) begin
            cd = (lat_min == lat_max) ? lat_min : int'($urandom_range(lat_min, lat_max));
            lat_q.push_back(cd);
         end
      end
   end

   // Monitor: any DUT memory/butterfly/unload event pops the scoreboard.
   always @(negedge clk) begin
      int  kind;
      int  addr;
      int  l;
      ev_t e;
      cyc++;
      if (rst) begin
         last_kind = 0;
      end else begin
         kind = 0;
         if (bus.mem_write) kind = 1 + int'(bus.mem_wsel);
         else if (bus.bf_lat_a) kind = 4;
         else if (bus.bf_lat_b) kind = 5;
         else if (bus.out_valid && bus.out_ready) kind = 6;
         addr = (kind >= 1 && kind <= 3) ? int'(bus.mem_waddr) : int'(bus.mem_raddr);
         if (bus.out_valid && !bus.out_ready && exp_q.size() > 0 && exp_q[0].kind == 6)
            check("unload stall raddr", int'(bus.mem_raddr), exp_q[0].addr);
         if (kind != 0) begin
            if (exp_q.size() == 0) begin
               check("unexpected event", kind, 0);
            end else begin
               e = exp_q.pop_front();
               check("event kind", kind, e.kind);
               check("event addr", addr, e.addr);
               if (kind == 4 || kind == 5) check("tw_idx", int'(bus.tw_idx), e.tw);
               check("bf_start", int'(bus.bf_start), int'(kind == 5));
               check("frame_done", int'(frame_done), e.last);
               check("busy", int'(busy), 1);
            end
            if (kind == 4 && last_kind == 1) first_rda = cyc;
            if (kind == 5) begin
               rdb_cnt++;
               rdb_cyc = cyc;
            end
            if (kind == 2 && lat_q.size() > 0) begin
               l = lat_q.pop_front();
               check("bf_wait cycles", cyc - rdb_cyc, l + 1);
            end
            if (kind == 3) last_wrb = cyc;
            last_kind = kind;
         end else begin
            check("frame_done stray", int'(frame_done), 0);
         end
         if (frame_done) begin
            comp_len = last_wrb - first_rda + 1;
            done_cnt++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      bus.in_valid  = rnd_in ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.out_ready = rnd_out ? 1'($urandom_range(0, 1)) : 1'b1;
      start         = (chaos && busy) ? ($urandom_range(0, 3) == 0) : 1'b0;
   endtask

   task automatic start_frame();
      step();
      start = 1'b1;
      step();
   endtask

   task automatic chk_idle(string tag);
      check({tag, " busy"}, int'(busy), 0);
      check({tag, " frame_done"}, int'(frame_done), 0);
      check({tag, " in_ready"}, int'(bus.in_ready), 0);
      check({tag, " out_valid"}, int'(bus.out_valid), 0);
      check({tag, " mem_write"}, int'(bus.mem_write), 0);
      check({tag, " mem_wsel"}, int'(bus.mem_wsel), 0);
      check({tag, " mem_waddr"}, int'(bus.mem_waddr), 0);
      check({tag, " mem_raddr"}, int'(bus.mem_raddr), 0);
      check({tag, " bf_lat_a"}, int'(bus.bf_lat_a), 0);
      check({tag, " bf_lat_b"}, int'(bus.bf_lat_b), 0);
      check({tag, " bf_start"}, int'(bus.bf_start), 0);
      check({tag, " tw_idx"}, int'(bus.tw_idx), 0);
   endtask

   task automatic run_frame();
      int base;
      int g;
      build_frame();
      base = done_cnt;
      start_frame();
      g = 0;
      while (done_cnt == base && g < 20000) begin
         step();
         g++;
      end
      check("frame completes", int'(done_cnt != base), 1);
      step();
      check("busy after frame", int'(busy), 0);
      check("scoreboard drained", exp_q.size(), 0);
   endtask

   initial begin
      int base;
      int g;
      rst           = 1'b1;
      start         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      #1;
      chk_idle("reset");
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk_idle("idle");

      // Back-to-back handshakes, unit butterfly latency: fixed compute length.
      run_frame();
      check("compute cycles", comp_len, 5 * (N / 2) * int'(AW));

      rnd_in   = 1;
      rnd_out  = 1;
      chaos    = 1;
      stray_en = 1;
      lat_min  = 1;
      lat_max  = 8;
      repeat (2) run_frame();

      // Asynchronous reset while waiting on a stage-3 butterfly.
      build_frame();
      base = rdb_cnt;
      start_frame();
      g = 0;
      while (rdb_cnt - base < 3 * (N / 2) + 3 && g < 20000) begin
         step();
         g++;
      end
      check("reach stage 3", int'(rdb_cnt - base >= 3 * (N / 2) + 3), 1);
      #1;
      rst = 1'b1;
      #1;
      chk_idle("reset in bf_wait");
      exp_q.delete();
      lat_q.delete();
      step();
      step();
      rst = 1'b0;
      chk_idle("after mid reset");
      run_frame();

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ifft_mem_ctrl.md
IFFT_MEM_CTRL -- requirements
Module: ifft_mem_ctrl

Interface
REQ-001 SHALL have parameter AW, default 5, meaning memory address width; N = 2**AW points, STAGES = AW.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port start, input, 1: begin a frame; sampled only in IDLE.
REQ-005 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-006 SHALL have ports in_valid (input, 1) and in_ready (output, 1): sample-load handshake.
REQ-007 SHALL have ports out_valid (output, 1) and out_ready (input, 1): result-unload handshake.
REQ-008 SHALL have ports mem_waddr (output, AW), mem_write (output, 1), mem_wsel (output, 2): write address, strobe, data select (00 input sample, 01 butterfly top, 10 butterfly bottom).
REQ-009 SHALL have port mem_raddr, output, AW: read address to the 28-bit x 32 working memory (combinational read).
REQ-010 SHALL have ports bf_lat_a, bf_lat_b, bf_start (output, 1 each): latch operand A, latch operand B, launch butterfly.
REQ-011 SHALL have ports tw_idx (output, AW-1): twiddle index; bf_done (input, 1): butterfly results ready.
REQ-012 SHALL have port frame_done, output, 1: one-cycle pulse at end of UNLOAD.

Function
REQ-013 SHALL implement states IDLE, LOAD, RD_A, RD_B, BF_WAIT, WR_A, WR_B, UNLOAD.
REQ-014 IDLE -> LOAD when start=1; start in any other state SHALL be ignored.
REQ-015 LOAD: in_ready=1; on in_valid&in_ready, mem_write=1, mem_wsel=00, mem_waddr=bitrev(load count); after N accepts -> RD_A with stage s=0, butterfly k=0.
REQ-016 Butterfly addresses: span=2**s, pos=k mod span, a=((k>>s)<<(s+1))|pos, b=a+span, tw_idx=pos<<(STAGES-1-s).
REQ-017 RD_A: mem_raddr=a, bf_lat_a=1, 1 cycle -> RD_B.
REQ-018 RD_B: mem_raddr=b, bf_lat_b=1, bf_start=1, 1 cycle -> BF_WAIT.
REQ-019 BF_WAIT: hold until bf_done=1, then -> WR_A; bf_done outside BF_WAIT SHALL be ignored.
REQ-020 WR_A: mem_waddr=a, mem_wsel=01, mem_write=1; WR_B: mem_waddr=b, mem_wsel=10, mem_write=1.
REQ-021 After WR_B: k<N/2-1 -> k+1, RD_A; else s<STAGES-1 -> s+1, k=0, RD_A; else -> UNLOAD, count 0.
REQ-022 UNLOAD: out_valid=1, mem_raddr=count (natural order); advance on out_ready; last transfer -> IDLE with frame_done=1 that cycle.
REQ-023 All strobes (mem_write, bf_*, in_ready, out_valid) SHALL be 0 in states not listed for them.
REQ-024 With bf_done returned 1 cycle after bf_start, compute phase SHALL take exactly 5*(N/2)*STAGES cycles (400 for AW=5).

Reset
REQ-025 rst SHALL force IDLE, s=k=count=0, all outputs 0, asynchronously, including mid-frame; memory contents are not cleared.
REQ-026 After rst deasserts, a new start SHALL run a complete frame normally.

Configuration
REQ-027 Macro IFFT_MEM_CTRL_BITREV_LOAD_EN defined: LOAD writes bitrev(count), UNLOAD reads count (REQ-015/022).
REQ-028 Macro undefined: LOAD writes count in natural order, UNLOAD reads bitrev(count); compute sequencing unchanged.

Structure
REQ-029 Package ifft_pkg SHALL hold AW default, state enum, mem_wsel codes and a bitrev function.
REQ-030 Sub-module ifft_addr_gen SHALL compute a, b, tw_idx combinationally from s and k.

Verification
REQ-031 Reset then start, 32 in_valid beats with bitrev enabled -> sample 1 at waddr 16, sample 3 at waddr 24, then RD_A.
REQ-032 s=0,k=0 -> raddr 0 then 1, tw_idx 0; s=2,k=5 -> a=9, b=13, tw_idx 4; s=4,k=5 -> a=5, b=21, tw_idx 5.
REQ-033 bf_done delayed 7 cycles -> controller holds BF_WAIT 7 cycles, no write; stray bf_done in RD_A -> ignored.
REQ-034 Full frame, bf_done latency 1, out_ready=1 -> exactly 400 compute cycles, 32 out beats raddr 0..31, frame_done one pulse, busy falls.
REQ-035 rst asserted in BF_WAIT at s=3 -> all outputs 0 immediately; next start restarts LOAD at count 0.
REQ-036 out_ready toggled 1/0 during UNLOAD and start pulsed while busy -> raddr holds while stalled, start ignored.
